// File: rtl/ctrl_decode_pipe.sv
// Decode-stage control for the 5-stage RV32 core: instruction decode, ID/EX control
// register with stall/flush, and a sequencer that stalls the pipe during multi-cycle M-ops.
module ctrl_decode_pipe #(
  parameter bit ENABLE_M   = 1'b1,
  parameter int MD_LATENCY = 4,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr_d,
  input  logic                  valid_d,
  input  logic                  stall_e,
  input  logic                  flush_e,
  output logic [2:0]            imm_src_d,
  output logic                  illegal_d,
  output logic                  reg_write_e,
  output logic                  mem_write_e,
  output logic                  branch_e,
  output logic                  jump_e,
  output logic                  jalr_e,
  output logic [2:0]            result_src_e,
  output logic                  alu_src_e,
  output logic                  alu_src_a_e,
  output logic [ALU_CTRL_W-1:0] alu_control_e,
  output logic [2:0]            funct3_e,
  output logic                  md_valid_e,
  output logic                  stall_md,
  output logic                  md_done
);

  localparam int CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (MD_LATENCY > 1) ? CNT_W'(MD_LATENCY - 2) : '0;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101,
                         ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111, ALU_SRL = 4'b1000,
                         ALU_SRA = 4'b1001;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [2:0] result_src;
    logic       alu_src;
    logic       alu_src_a;
    logic [3:0] alu_op;
    logic [2:0] funct3;
    logic       md_valid;
  } ctrl_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  ctrl_t      dec;
  ctrl_t      e_q;
  md_state_t  state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic       unused_bits;

  assign opcode = instr_d[6:0];
  assign funct3 = instr_d[14:12];
  assign funct7 = instr_d[31:25];
  assign unused_bits = ^{instr_d[24:15], instr_d[11:7]};

  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt,
                                             input logic is_r);
    case (f3)
      3'b000:  return (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // NOTE: every combinational output gets a default before the case so no path infers a latch.
  always_comb begin
    dec        = '0;
    legal      = 1'b0;
    imm_src_d  = 3'b000;
    dec.funct3 = funct3;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000001) begin
          if (ENABLE_M) begin
            legal          = 1'b1;
            dec.reg_write  = 1'b1;
            dec.result_src = 3'b100;
            dec.md_valid   = 1'b1;
          end
        end else if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          legal         = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_op    = alu_from_f3(funct3, funct7[5], 1'b1);
        end
      end
      7'b0010011: begin
        legal         = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = alu_from_f3(funct3, funct7[5], 1'b0);
      end
      7'b0000011: begin
        legal          = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 3'b001;
      end
      7'b0100011: begin
        legal         = 1'b1;
        imm_src_d     = 3'b001;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      7'b1100011: begin
        legal      = 1'b1;
        imm_src_d  = 3'b010;
        dec.branch = 1'b1;
        dec.alu_op = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
      end
      7'b1101111: begin
        legal          = 1'b1;
        imm_src_d      = 3'b011;
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 3'b010;
      end
      7'b1100111: begin
        legal          = 1'b1;
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.jalr       = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 3'b010;
      end
      7'b0110111: begin
        legal          = 1'b1;
        imm_src_d      = 3'b100;
        dec.reg_write  = 1'b1;
        dec.result_src = 3'b011;
      end
      7'b0010111: begin
        legal         = 1'b1;
        imm_src_d     = 3'b100;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_src_a = 1'b1;
      end
      default: ;
    endcase
    if (!legal) begin
      dec       = '0;
      imm_src_d = 3'b000;
    end
  end

  assign illegal_d = valid_d && !legal;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     e_q <= '0;
    else if (flush_e)               e_q <= '0;
    else if (!(stall_e || stall_md)) e_q <= (valid_d && legal) ? dec : '0;
  end

  assign reg_write_e   = e_q.reg_write;
  assign mem_write_e   = e_q.mem_write;
  assign branch_e      = e_q.branch;
  assign jump_e        = e_q.jump;
  assign jalr_e        = e_q.jalr;
  assign result_src_e  = e_q.result_src;
  assign alu_src_e     = e_q.alu_src;
  assign alu_src_a_e   = e_q.alu_src_a;
  assign alu_control_e = ALU_CTRL_W'(e_q.alu_op);
  assign funct3_e      = e_q.funct3;
  assign md_valid_e    = e_q.md_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // On the md_done cycle, go straight to IDLE if E advances so a following M-op
  // triggers on its first E cycle; park in DONE while stall_e holds the finished op.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    stall_md = 1'b0;
    md_done  = 1'b0;
    case (state)
      IDLE: begin
        if (md_valid_e) begin
          if (MD_LATENCY > 1) begin
            stall_md = 1'b1;
            state_n  = BUSY;
            cnt_n    = CNT_INIT;
          end else begin
            md_done = 1'b1;
            state_n = stall_e ? DONE : IDLE;
          end
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          md_done = 1'b1;
          state_n = stall_e ? DONE : IDLE;
        end else begin
          stall_md = 1'b1;
          cnt_n    = cnt - 1'b1;
        end
      end
      DONE: begin
        if (!stall_e) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (flush_e) begin
      state_n = IDLE;
      cnt_n   = '0;
      md_done = 1'b0;
    end
  end

endmodule
